// File: rtl/divisor_32_pkg.sv
// Shared ALU definitions: default datapath width and divider FSM state encoding.
package divisor_32_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/div_step.sv
// One restoring-division trial subtraction: partial remainder minus divisor magnitude.
// Purely combinational; borrow=1 means the divisor did not fit and the remainder is restored.
module div_step
   import divisor_32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   prem,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH:0]   diff,
   output logic             borrow
);

   assign {borrow, diff} = {1'b0, prem} - {2'b00, dvsr};

endmodule

// File: rtl/divisor_32.sv
// Iterative restoring divider, unsigned or two's-complement, one quotient bit per cycle.
// Latency WIDTH+2 cycles (2 on divide by zero); start is ignored while an operation is in flight.
module divisor_32
   import divisor_32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             f0,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             f0_reg;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] rem;
   // Holds the dividend magnitude; quotient bits shift in from the bottom as dividend bits leave the top.
   logic [WIDTH-1:0] dq;

   logic             a_neg_in;
   logic             b_neg_in;
   logic [WIDTH-1:0] a_mag_in;
   logic [WIDTH-1:0] b_mag_in;
   logic [WIDTH:0]   prem;
   logic [WIDTH:0]   step_diff;
   logic             step_borrow;
   logic             neg_q;
   logic             neg_r;
   logic             unused_diff_msb;

   assign a_neg_in = f0 & A[WIDTH-1];
   assign b_neg_in = f0 & B[WIDTH-1];
   assign a_mag_in = a_neg_in ? (~A + WIDTH'(1)) : A;
   assign b_mag_in = b_neg_in ? (~B + WIDTH'(1)) : B;

   assign prem = {rem, dq[WIDTH-1]};

   div_step #(.WIDTH(WIDTH)) u_step (
      .prem   (prem),
      .dvsr   (b_mag),
      .diff   (step_diff),
      .borrow (step_borrow)
   );

   // The remainder stays below the divisor, so the difference never needs its top bit.
   assign unused_diff_msb = step_diff[WIDTH];

   assign neg_q = f0_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
   assign neg_r = f0_reg & a_reg[WIDTH-1];
   assign busy  = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         f0_reg <= 1'b0;
         b_mag  <= '0;
         rem    <= '0;
         dq     <= '0;
         Q      <= '0;
         R      <= '0;
         done   <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_reg  <= A;
                  b_reg  <= B;
                  f0_reg <= f0;
                  b_mag  <= b_mag_in;
                  dq     <= a_mag_in;
                  rem    <= '0;
                  cnt    <= '0;
                  div0   <= 1'b0;
                  state  <= (B == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               rem <= step_borrow ? prem[WIDTH-1:0] : step_diff[WIDTH-1:0];
               dq  <= {dq[WIDTH-2:0], ~step_borrow};
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) state <= ST_DONE;
            end
            ST_DONE: begin
               done  <= 1'b1;
               state <= ST_IDLE;
               if (b_reg == '0) begin
                  Q    <= '1;
                  R    <= a_reg;
                  div0 <= 1'b1;
               end else begin
                  // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
                  Q <= neg_q ? (~dq + WIDTH'(1)) : dq;
                  R <= neg_r ? (~rem + WIDTH'(1)) : rem;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_32.sv
// Self-checking bench for divisor_32: directed corner cases plus randomized operands vs. an arithmetic model.
module tb_divisor_32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        f0 = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [31:0] Q;
   logic [31:0] R;
   logic        busy;
   logic        done;
   logic        div0;

   int n_checks = 0;
   int n_fail   = 0;

   divisor_32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .f0    (f0),
      .A     (A),
      .B     (B),
      .Q     (Q),
      .R     (R),
      .busy  (busy),
      .done  (done),
      .div0  (div0)
   );

   always #5 clk = ~clk;

   // Arithmetic reference: what the quotient/remainder should be, from plain integer division.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sf,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
      dz = 1'b0;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         dz = 1'b1;
      end else if (!sf) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endtask

   // Issues one start and waits for done. Latency counts cycles from the start edge,
   // including the cycle in which done is high.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sf,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int bcnt, output logic done_after,
                         output logic timeout);
      int cyc;
      A = a;
      B = b;
      f0 = sf;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      bcnt = 0;
      timeout = 1'b0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) bcnt++;
         if (cyc > 100) begin
            timeout = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      lat = cyc + 1;
      q = Q;
      r = R;
      dz = div0;
      @(posedge clk); #1;
      done_after = done;
   endtask

   task automatic test_reset;
      logic [31:0] q, r;
      logic dz, da, to;
      int lat, bc;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (Q !== 32'd0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", Q); end
      n_checks++; if (R !== 32'd0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", R); end
      n_checks++; if ({busy, done, div0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy/done/div0 got %b expected 000", {busy, done, div0}); end
      // First start is accepted on the very first edge with reset released.
      rst_n = 1'b1;
      run_op(32'd9, 32'd3, 1'b0, q, r, dz, lat, bc, da, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL first_start_timeout: no done seen"); end
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL first_start_latency: got %0d expected 34", lat); end
      n_checks++; if (q !== 32'd3 || r !== 32'd0) begin n_fail++; $display("FAIL first_start_result: got q=%h r=%h expected q=3 r=0", q, r); end
   endtask

   task automatic test_unsigned;
      logic [31:0] q, r;
      logic dz, da, to;
      int lat, bc;
      run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat, bc, da, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL unsigned_timeout: no done seen"); end
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 34", lat); end
      n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL unsigned_busy_cycles: got %0d expected 32", bc); end
      n_checks++; if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0) begin n_fail++; $display("FAIL unsigned_result: got q=%h r=%h div0=%b expected q=e r=2 div0=0", q, r, dz); end
      n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL unsigned_done_width: done still high one cycle later"); end
      // Outputs hold while idle.
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (Q !== 32'd14 || R !== 32'd2) begin n_fail++; $display("FAIL unsigned_hold: got q=%h r=%h expected q=e r=2", Q, R); end
   endtask

   task automatic test_signed;
      logic [31:0] q, r;
      logic dz, da, to;
      int lat, bc;
      run_op(32'hFFFF_FF9C, 32'd7, 1'b1, q, r, dz, lat, bc, da, to);
      n_checks++; if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || to !== 1'b0) begin n_fail++; $display("FAIL signed_neg_dividend: got q=%h r=%h expected q=fffffff2 r=fffffffe", q, r); end
      run_op(32'd100, 32'hFFFF_FFF9, 1'b1, q, r, dz, lat, bc, da, to);
      n_checks++; if (q !== 32'hFFFF_FFF2 || r !== 32'd2 || to !== 1'b0) begin n_fail++; $display("FAIL signed_neg_divisor: got q=%h r=%h expected q=fffffff2 r=2", q, r); end
   endtask

   task automatic test_div0;
      logic [31:0] q, r;
      logic dz, da, to;
      int lat, bc;
      for (int m = 0; m < 2; m++) begin
         run_op(32'd5, 32'd0, m[0], q, r, dz, lat, bc, da, to);
         n_checks++; if (lat !== 2 || to !== 1'b0) begin n_fail++; $display("FAIL div0_latency mode %0d: got %0d expected 2", m, lat); end
         n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL div0_busy mode %0d: got %0d busy cycles expected 0", m, bc); end
         n_checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd5 || dz !== 1'b1) begin n_fail++; $display("FAIL div0_result mode %0d: got q=%h r=%h div0=%b expected q=ffffffff r=5 div0=1", m, q, r, dz); end
         n_checks++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_hold mode %0d: got %b expected 1", m, div0); end
      end
   endtask

   task automatic test_overflow_and_zero;
      logic [31:0] q, r;
      logic dz, da, to;
      int lat, bc;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dz, lat, bc, da, to);
      n_checks++; if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin n_fail++; $display("FAIL overflow: got q=%h r=%h div0=%b expected q=80000000 r=0 div0=0", q, r, dz); end
      run_op(32'd0, 32'd13, 1'b1, q, r, dz, lat, bc, da, to);
      n_checks++; if (q !== 32'd0 || r !== 32'd0 || lat !== 34) begin n_fail++; $display("FAIL zero_dividend: got q=%h r=%h lat=%0d expected q=0 r=0 lat=34", q, r, lat); end
   endtask

   task automatic test_reset_mid_run;
      logic [31:0] q, r;
      logic dz, da, to;
      int lat, bc;
      logic saw_done;
      A = 32'd100;
      B = 32'd7;
      f0 = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0 || Q !== 32'd0 || R !== 32'd0) begin n_fail++; $display("FAIL mid_reset_clear: got busy=%b q=%h r=%h expected 0 0 0", busy, Q, R); end
      saw_done = done;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         saw_done |= done;
         @(posedge clk); #1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_done: got a done pulse expected none"); end
      run_op(32'd9, 32'd3, 1'b0, q, r, dz, lat, bc, da, to);
      n_checks++; if (q !== 32'd3 || r !== 32'd0 || to !== 1'b0) begin n_fail++; $display("FAIL mid_reset_restart: got q=%h r=%h expected q=3 r=0", q, r); end
   endtask

   task automatic test_start_while_busy;
      int pulses;
      logic [31:0] q, r;
      pulses = 0;
      q = 'x;
      r = 'x;
      A = 32'd100;
      B = 32'd7;
      f0 = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      A = 32'd1;
      B = 32'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done === 1'b1) begin
            pulses++;
            q = Q;
            r = R;
         end
         @(posedge clk); #1;
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d expected 1", pulses); end
      n_checks++; if (q !== 32'd14 || r !== 32'd2) begin n_fail++; $display("FAIL busy_start_result: got q=%h r=%h expected q=e r=2", q, r); end
   endtask

   task automatic test_random;
      logic [31:0] a, b, q, r, eq, er;
      logic sf, dz, edz, da, to;
      int lat, bc, elat;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 20);
            2: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
            default: b = $urandom;
         endcase
         sf = $urandom_range(0, 1);
         ref_div(a, b, sf, eq, er, edz);
         elat = edz ? 2 : 34;
         run_op(a, b, sf, q, r, dz, lat, bc, da, to);
         n_checks++;
         if (q !== eq || r !== er || dz !== edz || lat !== elat || to !== 1'b0) begin
            n_fail++;
            $display("FAIL random[%0d] a=%h b=%h f0=%b: got q=%h r=%h div0=%b lat=%0d expected q=%h r=%h div0=%b lat=%0d",
                     i, a, b, sf, q, r, dz, lat, eq, er, edz, elat);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_unsigned();
      test_signed();
      test_div0();
      test_overflow_and_zero();
      test_reset_mid_run();
      test_start_while_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/divisor_32.md
DIVISOR_32 -- requirements
Module: divisor_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have the port start, input, 1 bit: a request to begin a division; it is sampled only in IDLE.
REQ-005 The block SHALL have the port f0, input, 1 bit: 0 selects unsigned operands, 1 selects two's-complement operands; it is latched at start.
REQ-006 The block SHALL have the port A, input, WIDTH bits: the dividend, latched at start.
REQ-007 The block SHALL have the port B, input, WIDTH bits: the divisor, latched at start.
REQ-008 The block SHALL have the port Q, output, WIDTH bits: the quotient.
REQ-009 The block SHALL have the port R, output, WIDTH bits: the remainder.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while the FSM is in RUN.
REQ-011 The block SHALL have the port done, output, 1 bit: a one-cycle pulse when Q and R become valid.
REQ-012 The block SHALL have the port div0, output, 1 bit: high with done when B was zero; it holds until the next start.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch A, B and f0 and, on the next edge, go to RUN with the iteration counter at 0; if B=0, it SHALL go to DONE instead.
REQ-015 In RUN, the block SHALL perform one restoring step per cycle:
- shift the partial remainder left one bit, bringing in the next dividend magnitude bit (MSB first);
- do a (WIDTH+1)-bit trial subtraction of the divisor magnitude;
- if there is no borrow, keep the difference and set the quotient bit to 1;
- otherwise, restore the partial remainder and set the quotient bit to 0.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the step with counter = WIDTH-1, the FSM SHALL go to DONE.
REQ-017 In DONE, the block SHALL load Q and R with the sign-corrected results, assert done for exactly one cycle, and return to IDLE on the next edge.
REQ-018 Latency from the start edge to the done pulse SHALL be WIDTH+2 cycles for a nonzero divisor and 2 cycles for B=0.
REQ-019 The block SHALL ignore start while in RUN or DONE; this SHALL NOT disturb the operation in progress or the latched operands.
REQ-020 Q and R SHALL hold their last values until the next DONE; busy SHALL be 0 in IDLE and DONE.
REQ-021 Unsigned mode (f0=0) SHALL give Q = floor(A/B) and R = A - Q*B.
REQ-022 Signed mode (f0=1) SHALL divide the magnitudes, then:
- negate Q when sign(A) XOR sign(B) = 1;
- give R the sign of A (truncation toward zero).
REQ-023 On divide by zero, the block SHALL give Q = all ones, R = A as latched, and div0 = 1, in both modes.
REQ-024 On signed overflow (A = most negative value, B = -1), the block SHALL give Q = most negative value, R = 0, and div0 = 0.
REQ-025 A start with A=0 SHALL complete normally with Q=0 and R=0.

Reset
REQ-026 When rst_n=0 at an edge, the block SHALL enter IDLE and clear Q, R, busy, done, div0, the counter and the operand registers, from any state including mid-RUN.
REQ-027 An operation interrupted by reset SHALL produce no done pulse.
REQ-028 The first start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-029 The state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the WIDTH default SHALL live in the shared ALU package.
REQ-030 The trial subtraction SHALL be one combinational sub-module, div_step, with:
- inputs: the (WIDTH+1)-bit partial remainder and the WIDTH-bit divisor;
- outputs: the difference and the borrow.
REQ-031 Sign handling (magnitude extraction and result negation) SHALL be done inside divisor_32 using two's-complement invert-plus-one.

Verification
REQ-032 Unsigned: f0=0, A=100, B=7 -> done at start+34 cycles, Q=14, R=2, div0=0; busy high for exactly 32 cycles.
REQ-033 Signed: f0=1, A=-100 (0xFFFFFF9C), B=7 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2); and A=100, B=-7 -> Q=-14, R=2.
REQ-034 Divide by zero: A=5, B=0 in either mode -> done at start+2, Q=0xFFFFFFFF, R=5, div0=1; no busy cycle.
REQ-035 Overflow: f0=1, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, div0=0.
REQ-036 Reset mid-operation: rst_n=0 at RUN cycle 10 -> next edge has busy=0, Q=0, R=0, no done pulse; a fresh start with A=9, B=3 then gives Q=3, R=0.
REQ-037 Start while busy: pulse start with A=1, B=1 during RUN of 100/7 -> result is still Q=14, R=2, and only one done pulse occurs.
